// File: rtl/cp0_exc_ctrl.sv
// CP0 system-control block: BadVAddr, Count, Compare, Status, Cause, EPC with exception/ERET sequencing.
// Optional build macro CP0_RD_BYPASS_EN forwards a same-cycle MTC0 write to the MFC0 read port.
module cp0_exc_ctrl #(
  parameter int unsigned HW_INT_NUM   = 6,
  parameter int unsigned COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0040FF00,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            rd_addr,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_pc,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  int_pending,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0040FF03;
  localparam logic [4:0]  PRESC_LAST   = 5'(COUNT_DIV - 1);

  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           status_q, status_d;
  logic [31:0]           epc_q, epc_d;
  logic                  bd_q, bd_d;
  logic                  ti_q, ti_d;
  logic [4:0]            exccode_q, exccode_d;
  logic [1:0]            ipsw_q, ipsw_d;
  logic [HW_INT_NUM-1:0] hw_q;
  logic [4:0]            presc_q, presc_d;

  logic                  mtc0_we;
  logic [7:0]            ip_w;
  logic [31:0]           cause_w;

  // MTC0 only lands when neither an exception nor an ERET commits this cycle.
  assign mtc0_we = wr_en & ~exc_valid & ~eret;

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    exccode_d  = exccode_q;
    ipsw_d     = ipsw_q;
    presc_d    = presc_q;

    if (mtc0_we && wr_addr == REG_COUNT) begin
      count_d = wr_data;
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
      if (count_q + 32'd1 == compare_q) ti_d = 1'b1;
    end else begin
      presc_d = presc_q + 5'd1;
    end

    if (exc_valid) begin
      status_d[1] = 1'b1;
      exccode_d   = exc_code;
      if (!status_q[1]) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr_d = exc_badvaddr;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        REG_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (wr_data & STATUS_WMASK);
        REG_CAUSE:   ipsw_d   = wr_data[9:8];
        REG_EPC:     epc_d    = wr_data;
        // Placed after the count block so a same-cycle match is overridden by the clear.
        REG_COMPARE: begin
          compare_d = wr_data;
          ti_d      = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= RESET_STATUS;
      epc_q      <= '0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exccode_q  <= '0;
      ipsw_q     <= '0;
      hw_q       <= '0;
      presc_q    <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exccode_q  <= exccode_d;
      ipsw_q     <= ipsw_d;
      hw_q       <= hw_int;
      presc_q    <= presc_d;
    end
  end

  // IP7 is shared by the timer and the top HW line when all six lines are used.
  always_comb begin
    ip_w                    = '0;
    ip_w[1:0]               = ipsw_q;
    ip_w[2 +: HW_INT_NUM]   = hw_q;
    ip_w[7]                 = ip_w[7] | ti_q;
    cause_w                 = '0;
    cause_w[31]             = bd_q;
    cause_w[15:8]           = ip_w;
    cause_w[6:2]            = exccode_q;
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_BADVADDR: rd_data = badvaddr_q;
      REG_COUNT:    rd_data = count_q;
      REG_COMPARE:  rd_data = compare_q;
      REG_STATUS:   rd_data = status_q;
      REG_CAUSE:    rd_data = cause_w;
      REG_EPC:      rd_data = epc_q;
      default:      rd_data = '0;
    endcase
`ifdef CP0_RD_BYPASS_EN
    if (wr_en && wr_addr == rd_addr) begin
      case (wr_addr)
        REG_STATUS:  rd_data = (status_q & ~STATUS_WMASK) | (wr_data & STATUS_WMASK);
        REG_CAUSE:   rd_data = {cause_w[31:10], wr_data[9:8], cause_w[7:0]};
        REG_EPC:     rd_data = wr_data;
        REG_COMPARE: rd_data = wr_data;
        REG_COUNT:   rd_data = wr_data;
        default: ;
      endcase
    end
`endif
  end

  assign int_pending = status_q[0] & ~status_q[1] & (|(ip_w & status_q[15:8]));
  assign flush       = exc_valid | eret;
  assign flush_pc    = exc_valid ? EXC_VECTOR : epc_q;
  assign epc_o       = epc_q;
  assign timer_int_o = ti_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus random traffic against a register-level reference model.
module tb_cp0_exc_ctrl;

  localparam int unsigned HW  = 6;
  localparam int unsigned DIV = 2;

  logic          clk, rst;
  logic [4:0]    rd_addr, wr_addr, exc_code;
  logic [31:0]   rd_data, wr_data, exc_pc, exc_badvaddr, flush_pc, epc_o;
  logic          wr_en, exc_valid, exc_bd, eret, int_pending, flush, timer_int_o;
  logic [HW-1:0] hw_int;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: architectural register contents only.
  bit [31:0] m_badv, m_count, m_cmp, m_status, m_epc;
  bit        m_bd, m_ti;
  bit [4:0]  m_exc;
  bit [1:0]  m_ipsw;
  bit [7:0]  m_hw;
  int        m_presc;

  cp0_exc_ctrl #(.HW_INT_NUM(HW), .COUNT_DIV(DIV), .RESET_STATUS(32'h0040FF00),
                 .EXC_VECTOR(32'hBFC00380)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .hw_int(hw_int), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_bd(exc_bd), .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr),
    .eret(eret), .int_pending(int_pending), .flush(flush), .flush_pc(flush_pc),
    .epc_o(epc_o), .timer_int_o(timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] m_ip();
    return 8'(m_ipsw) | 8'(m_hw << 2) | (m_ti ? 8'h80 : 8'h00);
  endfunction

  function automatic bit [31:0] m_cause();
    return (m_bd ? 32'h8000_0000 : 32'h0) + (32'(m_ip()) * 256) + (32'(m_exc) * 4);
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] a);
    bit [31:0] v;
    case (a)
      5'd8:    v = m_badv;
      5'd9:    v = m_count;
      5'd11:   v = m_cmp;
      5'd12:   v = m_status;
      5'd13:   v = m_cause();
      5'd14:   v = m_epc;
      default: v = 0;
    endcase
`ifdef CP0_RD_BYPASS_EN
    if (wr_en && wr_addr == a) begin
      case (a)
        5'd12: v = (m_status & 32'hFFBF00FC) | (wr_data & 32'h0040FF03);
        5'd13: v = (m_cause() & 32'hFFFFFCFF) | (wr_data & 32'h00000300);
        5'd9, 5'd11, 5'd14: v = wr_data;
        default: ;
      endcase
    end
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_badv = 0; m_count = 0; m_cmp = 0; m_status = 32'h0040FF00; m_epc = 0;
    m_bd = 0; m_ti = 0; m_exc = 0; m_ipsw = 0; m_hw = 0; m_presc = 0;
  endtask

  task automatic model_step();
    bit we;
    bit [31:0] old_cmp;
    we = wr_en && !exc_valid && !eret;
    old_cmp = m_cmp;
    if (we && wr_addr == 5'd9) begin
      m_count = wr_data;
      m_presc = 0;
    end else begin
      m_presc = m_presc + 1;
      if (m_presc == DIV) begin
        m_presc = 0;
        m_count = m_count + 1;
        if (m_count == old_cmp) m_ti = 1;
      end
    end
    if (exc_valid) begin
      if (!m_status[1]) begin
        m_epc = exc_bd ? exc_pc - 4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_status[1] = 1;
      m_exc = exc_code;
      if (exc_code == 4 || exc_code == 5) m_badv = exc_badvaddr;
    end else if (eret) begin
      m_status[1] = 0;
    end else if (we) begin
      case (wr_addr)
        5'd12: begin
          m_status[22]   = wr_data[22];
          m_status[15:8] = wr_data[15:8];
          m_status[1:0]  = wr_data[1:0];
        end
        5'd13: m_ipsw = wr_data[9:8];
        5'd14: m_epc  = wr_data;
        5'd11: begin m_cmp = wr_data; m_ti = 0; end
        default: ;
      endcase
    end
    m_hw = 8'(hw_int);
  endtask

  task automatic check_outputs();
    check_eq("rd_data", rd_data, m_read(rd_addr));
    check_eq("flush", 32'(flush), 32'(exc_valid | eret));
    check_eq("flush_pc", flush_pc, exc_valid ? 32'hBFC00380 : m_epc);
    check_eq("epc_o", epc_o, m_epc);
    check_eq("timer_int", 32'(timer_int_o), 32'(m_ti));
    check_eq("int_pending", 32'(int_pending),
             32'(m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 0)));
  endtask

  // Checks outputs for the currently driven inputs, then clocks them in.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    wr_en = 0; wr_addr = 0; wr_data = 0; exc_valid = 0; exc_code = 0; exc_bd = 0;
    exc_pc = 0; exc_badvaddr = 0; eret = 0;
  endtask

  task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    quiet();
  endtask

  task automatic read_chk(input string tag, input bit [4:0] a, input bit [31:0] mask,
                          input bit [31:0] exp);
    rd_addr = a;
    #1;
    check_eq(tag, rd_data & mask, exp);
  endtask

  int addr_tbl[7] = '{8, 9, 11, 12, 13, 14, 0};
  bit hit;

  initial begin
    quiet();
    hw_int = 0; rd_addr = 0; rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();

    // Reset values and Count prescaling.
    read_chk("status_rst", 5'd12, 32'hFFFFFFFF, 32'h0040FF00);
    read_chk("cause_rst", 5'd13, 32'hFFFFFFFF, 32'h0);
    rd_addr = 5'd9;
    for (int i = 0; i < 10; i++) step();
    read_chk("count_10clk", 5'd9, 32'hFFFFFFFF, 32'd5);

    // Timer match, stickiness and clear.
    mtc0(5'd11, 32'd8);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000FF01);
    rd_addr = 5'd9;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (timer_int_o) hit = 1;
    end
    check_eq("ti_wait", 32'(hit), 32'd1);
    read_chk("count_at_ti", 5'd9, 32'hFFFFFFFF, 32'd8);
    check_eq("int_pend_ti", 32'(int_pending), 32'd1);
    step(); step();
    read_chk("count_9", 5'd9, 32'hFFFFFFFF, 32'd9);
    check_eq("ti_sticky", 32'(timer_int_o), 32'd1);
    mtc0(5'd11, 32'd1000);
    check_eq("ti_clear", 32'(timer_int_o), 32'd0);

    // Exception in a delay slot with address error.
    exc_valid = 1; exc_code = 5; exc_bd = 1; exc_pc = 32'h80001004; exc_badvaddr = 32'h3;
    #1;
    check_eq("exc_flush_pc", flush_pc, 32'hBFC00380);
    step();
    quiet();
    read_chk("exc1_epc", 5'd14, 32'hFFFFFFFF, 32'h80001000);
    read_chk("exc1_bd", 5'd13, 32'h80000000, 32'h80000000);
    read_chk("exc1_code", 5'd13, 32'h0000007C, 32'd5 << 2);
    read_chk("exc1_exl", 5'd12, 32'h2, 32'h2);
    read_chk("exc1_badv", 5'd8, 32'hFFFFFFFF, 32'h3);

    // Nested exception keeps EPC; ERET returns to it.
    exc_valid = 1; exc_code = 10; exc_bd = 0; exc_pc = 32'h80002000; exc_badvaddr = 32'hDEAD;
    step();
    quiet();
    read_chk("exc2_epc", 5'd14, 32'hFFFFFFFF, 32'h80001000);
    read_chk("exc2_code", 5'd13, 32'h0000007C, 32'd10 << 2);
    read_chk("exc2_badv", 5'd8, 32'hFFFFFFFF, 32'h3);
    eret = 1;
    #1;
    check_eq("eret_flush_pc", flush_pc, 32'h80001000);
    step();
    quiet();
    read_chk("eret_exl", 5'd12, 32'h2, 32'h0);

    // Exception beats ERET and MTC0 in the same cycle.
    exc_valid = 1; exc_code = 8; exc_pc = 32'h80003000; eret = 1;
    wr_en = 1; wr_addr = 5'd14; wr_data = 32'h1234;
    step();
    quiet();
    read_chk("prio_epc", 5'd14, 32'hFFFFFFFF, 32'h80003000);
    read_chk("prio_exl", 5'd12, 32'h2, 32'h2);
    eret = 1;
    step();
    quiet();

    // Hardware interrupt line 0 through IM2.
    mtc0(5'd12, 32'h00000401);
    hw_int = 1;
    #1;
    check_eq("hw_int_pre", 32'(int_pending), 32'd0);
    step();
    read_chk("hw_ip2", 5'd13, 32'h00000400, 32'h00000400);
    check_eq("hw_int_pend", 32'(int_pending), 32'd1);
    mtc0(5'd12, 32'h00000001);
    check_eq("hw_int_masked", 32'(int_pending), 32'd0);
    hw_int = 0;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      quiet();
      rd_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(addr_tbl[$urandom_range(0, 6)]);
      hw_int  = HW'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        wr_en   = 1;
        wr_addr = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'(addr_tbl[$urandom_range(0, 6)]);
        wr_data = $urandom;
        if (wr_addr == 5'd11) wr_data = m_count + $urandom_range(0, 4);
      end
      if ($urandom_range(0, 9) == 0) begin
        exc_valid    = 1;
        exc_code     = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
        exc_bd       = 1'($urandom);
        exc_pc       = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        exc_badvaddr = $urandom;
      end
      if ($urandom_range(0, 9) == 0) eret = 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
